// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/16-scan row scheduler: shift a row, blank, latch, then
// display with OE duty set by a per-row brightness latch.
module hub75_scan_ctrl #(
  parameter int COLS    = 64,
  parameter int ROWS    = 16,
  parameter int ON_UNIT = 8,
  parameter int COL_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       brightness,
  output logic [3:0]       data_row,
  output logic [COL_W-1:0] data_col,
  output logic             data_valid,
  output logic             sclk,
  output logic             lat,
  output logic             oe,
  output logic [3:0]       row_addr,
  output logic             frame_start,
  output logic             busy
);

  localparam int DISP = ROWS * ON_UNIT;
  localparam int DW   = $clog2(DISP);

  typedef enum logic [2:0] {
    IDLE, SHIFT, BLANK, LATCH, DISPLAY
  } state_e;

  state_e           state_q;
  logic [COL_W-1:0] col_q;
  logic             ph_q;
  logic [DW-1:0]    dcnt_q;
  logic [3:0]       row_q;
  logic [3:0]       bl_q;

  logic [3:0]       data_row_q;
  logic [COL_W-1:0] data_col_q;
  logic             data_valid_q;
  logic             sclk_q;
  logic             lat_q;
  logic             oe_q;
  logic [3:0]       row_addr_q;
  logic             frame_start_q;
  logic             busy_q;

  logic [3:0]  row_d;
  logic [11:0] lim_q_w;
  logic [11:0] lim_in_w;
  logic [11:0] dcnt_d;
  logic        col_last_w;
  logic        disp_last_w;

  assign row_d       = (row_q == 4'(ROWS - 1)) ? 4'd0 : row_q + 4'd1;
  assign lim_q_w     = 12'(bl_q) * 12'(ON_UNIT);
  assign lim_in_w    = 12'(brightness) * 12'(ON_UNIT);
  assign dcnt_d      = 12'(dcnt_q) + 12'd1;
  assign col_last_w  = (col_q == COL_W'(COLS - 1));
  assign disp_last_w = (dcnt_q == DW'(DISP - 1));

  // Outputs are computed for the cycle being entered, so every
  // panel pin comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      ph_q          <= 1'b0;
      dcnt_q        <= '0;
      row_q         <= 4'd0;
      bl_q          <= 4'd0;
      data_row_q    <= 4'd0;
      data_col_q    <= '0;
      data_valid_q  <= 1'b0;
      sclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_q          <= 1'b1;
      row_addr_q    <= 4'd0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      lat_q         <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q       <= SHIFT;
            row_q         <= 4'd0;
            col_q         <= '0;
            ph_q          <= 1'b0;
            data_row_q    <= 4'd0;
            data_col_q    <= '0;
            data_valid_q  <= 1'b1;
            sclk_q        <= 1'b0;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        SHIFT: begin
          if (!ph_q) begin
            ph_q   <= 1'b1;
            sclk_q <= 1'b1;
          end else if (col_last_w) begin
            state_q      <= BLANK;
            ph_q         <= 1'b0;
            sclk_q       <= 1'b0;
            data_valid_q <= 1'b0;
            row_addr_q   <= row_q;
          end else begin
            ph_q       <= 1'b0;
            sclk_q     <= 1'b0;
            col_q      <= col_q + 1'b1;
            data_col_q <= col_q + 1'b1;
          end
        end
        BLANK: begin
          state_q <= LATCH;
          lat_q   <= 1'b1;
        end
        LATCH: begin
          state_q <= DISPLAY;
          bl_q    <= brightness;
          dcnt_q  <= '0;
          oe_q    <= !(lim_in_w != 12'd0);
        end
        DISPLAY: begin
          if (disp_last_w) begin
            oe_q   <= 1'b1;
            dcnt_q <= '0;
            if (en) begin
              state_q       <= SHIFT;
              row_q         <= row_d;
              col_q         <= '0;
              ph_q          <= 1'b0;
              data_row_q    <= row_d;
              data_col_q    <= '0;
              data_valid_q  <= 1'b1;
              frame_start_q <= (row_d == 4'd0);
            end else begin
              state_q    <= IDLE;
              row_q      <= 4'd0;
              data_row_q <= 4'd0;
              data_col_q <= '0;
              row_addr_q <= 4'd0;
              busy_q     <= 1'b0;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
            oe_q   <= !(dcnt_d < lim_q_w);
          end
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_row    = data_row_q;
  assign data_col    = data_col_q;
  assign data_valid  = data_valid_q;
  assign sclk        = sclk_q;
  assign lat         = lat_q;
  assign oe          = oe_q;
  assign row_addr    = row_addr_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: row timing, OE duty,
// brightness latching, enable drop and asynchronous reset.
module tb_hub75_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] brightness;
  logic [3:0] data_row;
  logic [5:0] data_col;
  logic       data_valid;
  logic       sclk;
  logic       lat;
  logic       oe;
  logic [3:0] row_addr;
  logic       frame_start;
  logic       busy;

  hub75_scan_ctrl #(
    .COLS(64), .ROWS(16), .ON_UNIT(8), .COL_W(6)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .data_row(data_row), .data_col(data_col),
    .data_valid(data_valid), .sclk(sclk), .lat(lat), .oe(oe),
    .row_addr(row_addr), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int oe_low, lat_cyc, lat_n, rises, fs_n, col_err, viol;
  logic [3:0] addr;

  task automatic step;
    @(negedge clk);
  endtask

  // Bring the scanner up so the current sample is row 0, SHIFT cycle 0.
  task automatic start_scan(input logic [3:0] b);
    rst = 1'b1;
    en = 1'b0;
    brightness = b;
    step();
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  // Samples 258 cycles of one row starting at the current sample.
  task automatic observe_row(input int chg_at, input logic [3:0] chg_val,
                             input int drop_at);
    logic ps;
    logic [3:0] pra;
    oe_low = 0; lat_cyc = -1; lat_n = 0; rises = 0;
    fs_n = 0; col_err = 0; viol = 0; addr = 4'hx;
    ps = 1'b0;
    pra = row_addr;
    for (int k = 0; k < 258; k++) begin
      if (k == chg_at) brightness = chg_val;
      if (k == drop_at) en = 1'b0;
      if (!oe) oe_low++;
      if (lat) begin
        lat_n++;
        lat_cyc = k;
        addr = row_addr;
      end
      if (frame_start) fs_n++;
      if (sclk && !ps) begin
        if (data_col !== 6'(rises)) col_err++;
        rises++;
      end
      if (sclk && !data_valid) viol++;
      if (lat && !oe) viol++;
      if (!oe && row_addr !== pra) viol++;
      pra = row_addr;
      ps = sclk;
      step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; brightness = 4'd0;
    step();
    checks++;
    if ({oe, lat, sclk, data_valid, frame_start, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 100000",
               {oe, lat, sclk, data_valid, frame_start, busy});
    end
    checks++;
    if ({row_addr, data_row, data_col} !== 14'd0) begin
      errors++;
      $display("FAIL reset_idx got %h want 0", {row_addr, data_row, data_col});
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_first_row;
    start_scan(4'd15);
    checks++;
    if ({frame_start, data_valid, busy, sclk} !== 4'b1110 || data_col !== 6'd0) begin
      errors++;
      $display("FAIL first_shift got fs/dv/busy/sclk %b col %0d want 1110 col 0",
               {frame_start, data_valid, busy, sclk}, data_col);
    end
    observe_row(-1, 4'd0, -1);
    checks++;
    if (rises !== 64 || col_err !== 0) begin
      errors++;
      $display("FAIL first_sclk got rises %0d colerr %0d want 64 0", rises, col_err);
    end
    checks++;
    if (lat_cyc !== 129 || lat_n !== 1) begin
      errors++;
      $display("FAIL first_lat got cyc %0d n %0d want 129 1", lat_cyc, lat_n);
    end
    checks++;
    if (addr !== 4'd0 || fs_n !== 1 || viol !== 0) begin
      errors++;
      $display("FAIL first_misc got addr %0d fs %0d viol %0d want 0 1 0",
               addr, fs_n, viol);
    end
  endtask

  task automatic test_full_frame;
    int bad;
    bad = 0;
    start_scan(4'd15);
    for (int r = 0; r < 16; r++) begin
      observe_row(-1, 4'd0, -1);
      checks++;
      if (oe_low !== 120 || addr !== 4'(r) || fs_n !== (r == 0 ? 1 : 0)
          || lat_cyc !== 129 || viol !== 0) begin
        errors++;
        $display("FAIL frame_row%0d got oe %0d addr %0d fs %0d lat %0d viol %0d want 120 %0d %0d 129 0",
                 r, oe_low, addr, fs_n, lat_cyc, viol, r, (r == 0 ? 1 : 0));
      end
    end
    checks++;
    if (frame_start !== 1'b1 || data_row !== 4'd0 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap got fs %b row %0d dv %b want 1 0 1",
               frame_start, data_row, data_valid);
    end
  endtask

  task automatic test_brightness_low;
    int tot;
    tot = 0;
    start_scan(4'd0);
    for (int r = 0; r < 16; r++) begin
      observe_row(-1, 4'd0, -1);
      tot += oe_low;
    end
    checks++;
    if (tot !== 0) begin
      errors++;
      $display("FAIL dark_frame got oe_low %0d want 0", tot);
    end
    brightness = 4'd1;
    observe_row(-1, 4'd0, -1);
    checks++;
    if (oe_low !== 8 || fs_n !== 1) begin
      errors++;
      $display("FAIL bright1 got oe_low %0d fs %0d want 8 1", oe_low, fs_n);
    end
  endtask

  task automatic test_brightness_change;
    start_scan(4'd15);
    for (int r = 0; r < 3; r++) observe_row(-1, 4'd0, -1);
    observe_row(200, 4'd4, -1);
    checks++;
    if (oe_low !== 120 || addr !== 4'd3) begin
      errors++;
      $display("FAIL chg_row3 got oe %0d addr %0d want 120 3", oe_low, addr);
    end
    observe_row(-1, 4'd0, -1);
    checks++;
    if (oe_low !== 32 || addr !== 4'd4) begin
      errors++;
      $display("FAIL chg_row4 got oe %0d addr %0d want 32 4", oe_low, addr);
    end
  endtask

  task automatic test_en_drop;
    start_scan(4'd15);
    for (int r = 0; r < 5; r++) observe_row(-1, 4'd0, -1);
    observe_row(-1, 4'd0, 10);
    checks++;
    if (oe_low !== 120 || lat_n !== 1 || lat_cyc !== 129 || addr !== 4'd5) begin
      errors++;
      $display("FAIL drop_row5 got oe %0d latn %0d latc %0d addr %0d want 120 1 129 5",
               oe_low, lat_n, lat_cyc, addr);
    end
    checks++;
    if ({busy, oe, data_valid, sclk} !== 4'b0100) begin
      errors++;
      $display("FAIL drop_idle got busy/oe/dv/sclk %b want 0100",
               {busy, oe, data_valid, sclk});
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold got busy %b want 0", busy);
    end
    en = 1'b1;
    step();
    checks++;
    if ({frame_start, busy, data_valid} !== 3'b111 || data_row !== 4'd0) begin
      errors++;
      $display("FAIL drop_restart got fs/busy/dv %b row %0d want 111 0",
               {frame_start, busy, data_valid}, data_row);
    end
  endtask

  task automatic test_async_reset;
    start_scan(4'd15);
    observe_row(-1, 4'd0, -1);
    observe_row(-1, 4'd0, -1);
    for (int k = 0; k < 140; k++) step();
    checks++;
    if (oe !== 1'b0 || row_addr !== 4'd2) begin
      errors++;
      $display("FAIL pre_rst got oe %b addr %0d want 0 2", oe, row_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({oe, lat, sclk, busy} !== 4'b1000 || row_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_rst got oe/lat/sclk/busy %b addr %0d want 1000 0",
               {oe, lat, sclk, busy}, row_addr);
    end
    step();
    rst = 1'b0;
    en = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    brightness = 4'd0;
    test_reset();
    test_first_row();
    test_full_frame();
    test_brightness_low();
    test_brightness_change();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
